pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter PAYLOAD_W, default 133, SHALL set the datapath payload width (Imm, Branch_addr, Jump_addr, ALUResult at 32 bits each, plus Wreg_addr at 5 bits).
REQ-002 Parameter CTRL_W, default 7, SHALL set the control-bit width (PCSrc, JtoPC, Branch, RegWrite, MemWrite, MemRead, MemtoReg).
REQ-003 Parameter SKID, default 1, SHALL enable (1) or disable (0) the second (skid) entry.
REQ-004 Parameter CNT_W, default 16, SHALL set the stall-counter width.
REQ-005 CLK  input  1  the single clock; all state changes on its rising edge.
REQ-006 RST_N  input  1  reset, asynchronous and active-low.
REQ-007 in_valid  input  1  upstream stage holds a valid instruction.
REQ-008 in_ready  output  1  this stage accepts on this cycle.
REQ-009 in_data  input  PAYLOAD_W  upstream payload.
REQ-010 in_ctrl  input  CTRL_W  upstream control bits.
REQ-011 flush  input  1  synchronous kill of all held entries, e.g. on a taken branch or jump.
REQ-012 out_valid  output  1  head entry valid.
REQ-013 out_ready  input  1  downstream accepts.
REQ-014 out_data  output  PAYLOAD_W  head payload.
REQ-015 out_ctrl  output  CTRL_W  head control bits; all-zero whenever out_valid=0.
REQ-016 stall_cnt  output  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

Function
REQ-017 Accept SHALL occur when in_valid and in_ready are both 1; release SHALL occur when out_valid and out_ready are both 1.
REQ-018 Occupancy states SHALL be EMPTY, ONE and TWO; TWO is reachable only when SKID=1.
REQ-019 Transitions SHALL be:
- EMPTY, on accept -> ONE
- ONE, accept without release -> TWO (SKID=1), otherwise stays ONE
- ONE, release without accept -> EMPTY
- TWO, release -> ONE
REQ-020 in_ready SHALL be 1 in EMPTY and ONE and 0 in TWO when SKID=1.
- With SKID=0, in_ready SHALL equal (state==EMPTY) or out_ready; this is the only combinational path.
REQ-021 Latency SHALL be one cycle: an entry accepted in cycle N presents on out_* in cycle N+1 if the stage was EMPTY.
REQ-022 Ordering SHALL be strict FIFO: the skid entry moves to head on the same edge that the head is released.
REQ-023 In ONE, a simultaneous accept and release SHALL replace the head and the state SHALL remain ONE.
REQ-024 Payload and control SHALL be captured unmodified; no bit of in_data or in_ctrl is altered.
REQ-025 While out_valid=1 and out_ready=0, out_data and out_ctrl SHALL hold stable.
REQ-026 flush=1 SHALL force EMPTY on the next edge and SHALL take priority over a same-cycle accept, which is discarded.
- out_valid and out_ctrl SHALL be 0 in the following cycle.
REQ-027 After a flush, payload registers MAY retain stale values; control bits SHALL read zero, so RegWrite and MemWrite bubbles are harmless.
REQ-028 stall_cnt SHALL increment by 1 per stalled cycle, saturate at all-ones, never wrap, and be unaffected by flush.

Reset
REQ-029 RST_N low SHALL immediately set, independent of CLK: state EMPTY, out_valid 0, out_data 0, out_ctrl 0, stall_cnt 0.
REQ-030 in_ready SHALL be 1 from the first cycle after RST_N deasserts.
REQ-031 Reset asserted mid-transfer SHALL discard all entries with no partial output.

Structure
REQ-032 A shared package SHALL hold the occupancy-state enum and the default widths (PAYLOAD_W 133, CTRL_W 7), plus the named control-bit indices PCSRC through MEMTOREG.
REQ-033 One sub-module, pipe_entry (valid + payload + ctrl register with load enable), SHALL be instantiated once for the head and once for the skid entry.

Verification
REQ-034 Reset: hold RST_N=0, drive in_valid=1 -> out_valid=0, out_ctrl=0, in_ready=1 after release.
REQ-035 Stream: out_ready=1, payloads 1, 2, 3 on consecutive cycles -> out_data 1, 2, 3 each one cycle later, with no bubbles.
REQ-036 Backpressure (SKID=1): out_ready=0, push A then B -> in_ready=0 after B; C is held off; raise out_ready -> A, B, C emerge in order; stall_cnt equals the stalled cycles.
REQ-037 Flush: state TWO, flush=1 with in_valid=1 and in_ctrl=7'h7F -> next cycle out_valid=0, out_ctrl=0, and the flushed instruction never appears.
REQ-038 Saturation (CNT_W=4): 20 stalled cycles -> stall_cnt=15 and stays 15.
REQ-039 SKID=0: out_ready toggling every cycle with constant in_valid -> throughput matches out_ready and no entry is lost or duplicated.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the pipeline stage register: occupancy states,
// default datapath widths and the bit positions of each control signal.
package pipe_stage_reg_pkg;

    localparam int DEF_PAYLOAD_W = 133;
    localparam int DEF_CTRL_W    = 7;

    localparam int PCSRC    = 6;
    localparam int JTOPC    = 5;
    localparam int BRANCH   = 4;
    localparam int REGWRITE = 3;
    localparam int MEMWRITE = 2;
    localparam int MEMREAD  = 1;
    localparam int MEMTOREG = 0;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_state_t;

endpackage

// File: rtl/pipe_stage_reg_entry.sv
// One held instruction: valid flag, payload and control bits with load and clear.
// Clearing drops the control bits to zero but leaves the payload stale on purpose.
module pipe_entry
    import pipe_stage_reg_pkg::*;
#(
    parameter int PAYLOAD_W = DEF_PAYLOAD_W,
    parameter int CTRL_W    = DEF_CTRL_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_load,
    input  logic                 i_clear,
    input  logic [PAYLOAD_W-1:0] i_data,
    input  logic [CTRL_W-1:0]    i_ctrl,
    output logic                 o_valid,
    output logic [PAYLOAD_W-1:0] o_data,
    output logic [CTRL_W-1:0]    o_ctrl
);

    logic                 r_valid;
    logic [PAYLOAD_W-1:0] r_data;
    logic [CTRL_W-1:0]    r_ctrl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_ctrl  <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_ctrl  <= i_ctrl;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_ctrl  = r_ctrl;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, optional skid entry,
// synchronous flush and a saturating downstream-stall counter.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int PAYLOAD_W = DEF_PAYLOAD_W,
    parameter int CTRL_W    = DEF_CTRL_W,
    parameter int SKID      = 1,
    parameter int CNT_W     = 16
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_data,
    input  logic [CTRL_W-1:0]    in_ctrl,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_data,
    output logic [CTRL_W-1:0]    out_ctrl,
    output logic [CNT_W-1:0]     stall_cnt
);

    occ_state_t           r_state;
    occ_state_t           w_next_state;
    logic [CNT_W-1:0]     r_stall_cnt;

    logic                 w_accept;
    logic                 w_release;
    logic                 w_head_load;
    logic                 w_head_clear;
    logic                 w_skid_load;
    logic                 w_skid_clear;
    logic                 w_skid_valid;
    logic [PAYLOAD_W-1:0] w_skid_data;
    logic [CTRL_W-1:0]    w_skid_ctrl;
    logic [PAYLOAD_W-1:0] w_head_data;
    logic [CTRL_W-1:0]    w_head_ctrl;

    // Without a skid entry, a full stage can only take a new word when the head leaves.
    always_comb begin
        if (SKID != 0) begin
            in_ready = (r_state != OCC_TWO);
        end else begin
            in_ready = (r_state == OCC_EMPTY) || out_ready;
        end
    end

    assign w_accept  = in_valid && in_ready;
    assign w_release = out_valid && out_ready;

    always_comb begin
        w_next_state = r_state;
        w_head_load  = 1'b0;
        w_head_clear = 1'b0;
        w_skid_load  = 1'b0;
        w_skid_clear = 1'b0;
        if (flush) begin
            w_next_state = OCC_EMPTY;
            w_head_clear = 1'b1;
            w_skid_clear = 1'b1;
        end else begin
            case (r_state)
                OCC_EMPTY: begin
                    if (w_accept) begin
                        w_head_load  = 1'b1;
                        w_next_state = OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (w_accept && w_release) begin
                        w_head_load = 1'b1;
                    end else if (w_accept && (SKID != 0)) begin
                        w_skid_load  = 1'b1;
                        w_next_state = OCC_TWO;
                    end else if (w_release) begin
                        w_head_clear = 1'b1;
                        w_next_state = OCC_EMPTY;
                    end
                end
                OCC_TWO: begin
                    if (w_release) begin
                        w_head_load  = 1'b1;
                        w_skid_clear = 1'b1;
                        w_next_state = OCC_ONE;
                    end
                end
                default: begin
                    w_next_state = OCC_EMPTY;
                    w_head_clear = 1'b1;
                    w_skid_clear = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= OCC_EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    // The skid entry, when occupied, is always older than anything upstream.
    assign w_head_data = w_skid_valid ? w_skid_data : in_data;
    assign w_head_ctrl = w_skid_valid ? w_skid_ctrl : in_ctrl;

    pipe_entry #(
        .PAYLOAD_W (PAYLOAD_W),
        .CTRL_W    (CTRL_W)
    ) u_head (
        .clk     (CLK),
        .rst_n   (RST_N),
        .i_load  (w_head_load),
        .i_clear (w_head_clear),
        .i_data  (w_head_data),
        .i_ctrl  (w_head_ctrl),
        .o_valid (out_valid),
        .o_data  (out_data),
        .o_ctrl  (out_ctrl)
    );

    pipe_entry #(
        .PAYLOAD_W (PAYLOAD_W),
        .CTRL_W    (CTRL_W)
    ) u_skid (
        .clk     (CLK),
        .rst_n   (RST_N),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_data  (in_data),
        .i_ctrl  (in_ctrl),
        .o_valid (w_skid_valid),
        .o_data  (w_skid_data),
        .o_ctrl  (w_skid_ctrl)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_stall_cnt <= '0;
        end else if (out_valid && !out_ready && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomized self-checking bench: three stage instances (skid, 4-bit counter, no skid)
// compared every cycle against a queue-based model of a bounded FIFO.
module tb_pipe_stage_reg;

    typedef struct packed {
        logic [132:0] d;
        logic [6:0]   c;
    } ent_t;

    logic         CLK;
    logic         RST_N;
    logic         iv  [3];
    logic         ir  [3];
    logic         fl  [3];
    logic         ov  [3];
    logic         ord [3];
    logic [132:0] id  [3];
    logic [132:0] od  [3];
    logic [6:0]   ic  [3];
    logic [6:0]   oc  [3];
    logic [15:0]  scA;
    logic [3:0]   scB;
    logic [15:0]  scC;

    ent_t mq [3][$];
    int   mc [3];
    int   mmax [3];
    int   nChecks;
    int   nPass;

    pipe_stage_reg #(.SKID(1)) dut_a (
        .CLK(CLK), .RST_N(RST_N), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
        .in_ctrl(ic[0]), .flush(fl[0]), .out_valid(ov[0]), .out_ready(ord[0]),
        .out_data(od[0]), .out_ctrl(oc[0]), .stall_cnt(scA)
    );

    pipe_stage_reg #(.SKID(1), .CNT_W(4)) dut_b (
        .CLK(CLK), .RST_N(RST_N), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
        .in_ctrl(ic[1]), .flush(fl[1]), .out_valid(ov[1]), .out_ready(ord[1]),
        .out_data(od[1]), .out_ctrl(oc[1]), .stall_cnt(scB)
    );

    pipe_stage_reg #(.SKID(0)) dut_c (
        .CLK(CLK), .RST_N(RST_N), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(id[2]),
        .in_ctrl(ic[2]), .flush(fl[2]), .out_valid(ov[2]), .out_ready(ord[2]),
        .out_data(od[2]), .out_ctrl(oc[2]), .stall_cnt(scC)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [132:0] rnd133();
        logic [159:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return t[132:0];
    endfunction

    task automatic idleInputs();
        for (int k = 0; k < 3; k++) begin
            iv[k]  = 1'b0;
            fl[k]  = 1'b0;
            ord[k] = 1'b1;
            id[k]  = '0;
            ic[k]  = '0;
        end
    endtask

    task automatic clearModel();
        for (int k = 0; k < 3; k++) begin
            mq[k].delete();
            mc[k] = 0;
        end
    endtask

    // Model: instance 2 holds one word and may take a new one only while emptying;
    // the others hold two. Advances one clock and returns at the next falling edge.
    task automatic tick();
        bit acc [3];
        bit rel [3];
        for (int k = 0; k < 3; k++) begin
            bit rdy;
            rdy    = (k == 2) ? (mq[k].size() == 0 || ord[k] === 1'b1) : (mq[k].size() < 2);
            acc[k] = (iv[k] === 1'b1) && rdy;
            rel[k] = (mq[k].size() > 0) && (ord[k] === 1'b1);
            if (mq[k].size() > 0 && ord[k] !== 1'b1 && mc[k] < mmax[k]) mc[k]++;
        end
        @(posedge CLK);
        for (int k = 0; k < 3; k++) begin
            if (fl[k] === 1'b1) begin
                mq[k].delete();
            end else begin
                if (rel[k]) void'(mq[k].pop_front());
                if (acc[k]) begin
                    ent_t e;
                    e.d = id[k];
                    e.c = ic[k];
                    mq[k].push_back(e);
                end
            end
        end
        @(negedge CLK);
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        for (int k = 0; k < 3; k++) begin
            iv[k] = 1'b1; fl[k] = 1'b0; ord[k] = 1'b1; id[k] = rnd133(); ic[k] = 7'h7F;
        end
        repeat (3) begin
            @(negedge CLK);
            for (int k = 0; k < 3; k++) begin
                nChecks++;
                if (ov[k] !== 1'b0 || oc[k] !== 7'd0 || od[k] !== 133'd0)
                    $display("[TB] FAIL reset_outputs dut%0d: valid=%b ctrl=%h data=%h, want 0/0/0", k, ov[k], oc[k], od[k]);
                else nPass++;
            end
        end
        nChecks++;
        if (scA !== 16'd0 || scB !== 4'd0 || scC !== 16'd0)
            $display("[TB] FAIL reset_stall_cnt: %0d/%0d/%0d, want 0", scA, scB, scC);
        else nPass++;
        idleInputs();
        RST_N = 1'b1;
        clearModel();
        #1;
        for (int k = 0; k < 3; k++) begin
            nChecks++;
            if (ir[k] !== 1'b1) $display("[TB] FAIL reset_in_ready dut%0d: got %b want 1", k, ir[k]);
            else nPass++;
        end
    endtask

    task automatic test_stream();
        ord[0] = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            iv[0] = 1'b1;
            id[0] = 133'(i);
            ic[0] = 7'($urandom());
            tick();
            nChecks++;
            if (ov[0] !== 1'b1 || od[0] !== 133'(i) || oc[0] !== ic[0])
                $display("[TB] FAIL stream_word%0d: valid=%b data=%0d ctrl=%h, want 1/%0d/%h", i, ov[0], od[0], oc[0], i, ic[0]);
            else nPass++;
        end
        iv[0] = 1'b0;
        tick();
        nChecks++;
        if (ov[0] !== 1'b0 || oc[0] !== 7'd0)
            $display("[TB] FAIL stream_drain: valid=%b ctrl=%h, want 0/00", ov[0], oc[0]);
        else nPass++;
    endtask

    task automatic test_backpressure();
        logic [132:0] wordA, wordB, wordC;
        logic [6:0]   ctrlA;
        int           base;
        base  = mc[0];
        wordA = rnd133(); wordB = rnd133(); wordC = rnd133();
        ctrlA = 7'($urandom());
        ord[0] = 1'b0;
        iv[0] = 1'b1; id[0] = wordA; ic[0] = ctrlA;
        tick();
        id[0] = wordB; ic[0] = 7'($urandom());
        tick();
        id[0] = wordC; ic[0] = 7'($urandom());
        #1;
        nChecks++;
        if (ir[0] !== 1'b0) $display("[TB] FAIL bp_full_in_ready: got %b want 0", ir[0]);
        else nPass++;
        repeat (3) begin
            tick();
            nChecks++;
            if (ov[0] !== 1'b1 || od[0] !== wordA || oc[0] !== ctrlA || ir[0] !== 1'b0)
                $display("[TB] FAIL bp_hold: valid=%b ctrl=%h ready=%b, want 1/%h/0 (data match=%b)", ov[0], oc[0], ir[0], ctrlA, od[0] === wordA);
            else nPass++;
        end
        ord[0] = 1'b1;
        tick();
        nChecks++;
        if (od[0] !== wordB) $display("[TB] FAIL bp_order_B: got %h want %h", od[0], wordB);
        else nPass++;
        tick();
        nChecks++;
        if (od[0] !== wordC || ov[0] !== 1'b1) $display("[TB] FAIL bp_order_C: got %h want %h", od[0], wordC);
        else nPass++;
        iv[0] = 1'b0;
        tick();
        nChecks++;
        if (ov[0] !== 1'b0) $display("[TB] FAIL bp_empty: valid=%b want 0", ov[0]);
        else nPass++;
        nChecks++;
        if (scA !== 16'(base + 4)) $display("[TB] FAIL bp_stall_cnt: got %0d want %0d", scA, base + 4);
        else nPass++;
    endtask

    task automatic test_flush();
        ord[0] = 1'b0;
        iv[0] = 1'b1; id[0] = rnd133(); ic[0] = 7'h7F;
        tick();
        id[0] = rnd133();
        tick();
        fl[0] = 1'b1; id[0] = rnd133(); ic[0] = 7'h7F;
        tick();
        fl[0] = 1'b0; iv[0] = 1'b0;
        nChecks++;
        if (ov[0] !== 1'b0 || oc[0] !== 7'd0)
            $display("[TB] FAIL flush_two: valid=%b ctrl=%h, want 0/00", ov[0], oc[0]);
        else nPass++;
        ord[0] = 1'b1;
        repeat (3) begin
            tick();
            nChecks++;
            if (ov[0] !== 1'b0) $display("[TB] FAIL flush_ghost: valid=%b want 0", ov[0]);
            else nPass++;
        end
        ord[0] = 1'b0;
        iv[0] = 1'b1; id[0] = rnd133(); ic[0] = 7'h7F;
        tick();
        fl[0] = 1'b1; ord[0] = 1'b1; id[0] = rnd133();
        tick();
        fl[0] = 1'b0; iv[0] = 1'b0;
        nChecks++;
        if (ov[0] !== 1'b0 || oc[0] !== 7'd0)
            $display("[TB] FAIL flush_one_accept: valid=%b ctrl=%h, want 0/00", ov[0], oc[0]);
        else nPass++;
    endtask

    task automatic test_saturation();
        ord[1] = 1'b0;
        iv[1] = 1'b1; id[1] = rnd133(); ic[1] = 7'($urandom());
        tick();
        iv[1] = 1'b0;
        for (int i = 1; i <= 25; i++) begin
            int want;
            tick();
            want = (i > 15) ? 15 : i;
            nChecks++;
            if (scB !== 4'(want)) $display("[TB] FAIL sat_cycle%0d: got %0d want %0d", i, scB, want);
            else nPass++;
        end
        ord[1] = 1'b1;
        tick();
        nChecks++;
        if (ov[1] !== 1'b0 || scB !== 4'd15)
            $display("[TB] FAIL sat_drain: valid=%b cnt=%0d, want 0/15", ov[1], scB);
        else nPass++;
    endtask

    task automatic test_skid0();
        int seq, expOut, ordHigh;
        bit acc;
        seq = 0; expOut = 0; ordHigh = 0;
        iv[2] = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            ord[2] = 1'((cyc % 2) == 1);
            id[2]  = 133'(seq);
            ic[2]  = 7'(seq);
            #1;
            nChecks++;
            if (ir[2] !== ((cyc == 0) ? 1'b1 : ord[2]))
                $display("[TB] FAIL skid0_in_ready cyc%0d: got %b want %b", cyc, ir[2], (cyc == 0) ? 1'b1 : ord[2]);
            else nPass++;
            if (ov[2] === 1'b1 && ord[2] === 1'b1) begin
                nChecks++;
                if (od[2] !== 133'(expOut)) $display("[TB] FAIL skid0_order: got %0d want %0d", od[2], expOut);
                else nPass++;
                expOut++;
            end
            if (cyc >= 1 && ord[2] === 1'b1) ordHigh++;
            acc = (mq[2].size() == 0) || (ord[2] === 1'b1);
            tick();
            if (acc) seq++;
        end
        iv[2] = 1'b0;
        nChecks++;
        if (expOut != ordHigh || expOut != 15)
            $display("[TB] FAIL skid0_throughput: released %0d want %0d", expOut, ordHigh);
        else nPass++;
        ord[2] = 1'b1;
        tick();
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 300; cyc++) begin
            for (int k = 0; k < 3; k += 2) begin
                iv[k]  = 1'(($urandom() % 4) != 0);
                id[k]  = rnd133();
                ic[k]  = 7'($urandom());
                ord[k] = 1'(($urandom() % 3) != 0);
                fl[k]  = 1'(($urandom() % 16) == 0);
            end
            #1;
            nChecks++;
            if (ir[0] !== 1'(mq[0].size() < 2) || ir[2] !== 1'(mq[2].size() == 0 || ord[2] === 1'b1))
                $display("[TB] FAIL rand_in_ready cyc%0d: got %b/%b", cyc, ir[0], ir[2]);
            else nPass++;
            tick();
            for (int k = 0; k < 3; k += 2) begin
                nChecks++;
                if (ov[k] !== 1'(mq[k].size() > 0))
                    $display("[TB] FAIL rand_valid dut%0d cyc%0d: got %b want %b", k, cyc, ov[k], mq[k].size() > 0);
                else if (mq[k].size() > 0 && (od[k] !== mq[k][0].d || oc[k] !== mq[k][0].c))
                    $display("[TB] FAIL rand_head dut%0d cyc%0d: ctrl=%h want %h (data match=%b)", k, cyc, oc[k], mq[k][0].c, od[k] === mq[k][0].d);
                else if (mq[k].size() == 0 && oc[k] !== 7'd0)
                    $display("[TB] FAIL rand_bubble_ctrl dut%0d cyc%0d: got %h want 00", k, cyc, oc[k]);
                else nPass++;
            end
            nChecks++;
            if (scA !== 16'(mc[0]) || scC !== 16'(mc[2]))
                $display("[TB] FAIL rand_stall_cnt cyc%0d: got %0d/%0d want %0d/%0d", cyc, scA, scC, mc[0], mc[2]);
            else nPass++;
        end
        idleInputs();
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        ord[0] = 1'b0;
        iv[0] = 1'b1; id[0] = rnd133(); ic[0] = 7'h7F;
        tick();
        id[0] = rnd133();
        tick();
        #2;
        RST_N = 1'b0;
        #1;
        nChecks++;
        if (ov[0] !== 1'b0 || oc[0] !== 7'd0 || od[0] !== 133'd0 || scA !== 16'd0)
            $display("[TB] FAIL midreset_async: valid=%b ctrl=%h cnt=%0d, want 0/00/0", ov[0], oc[0], scA);
        else nPass++;
        clearModel();
        @(negedge CLK);
        idleInputs();
        RST_N = 1'b1;
        #1;
        nChecks++;
        if (ir[0] !== 1'b1) $display("[TB] FAIL midreset_in_ready: got %b want 1", ir[0]);
        else nPass++;
        tick();
        nChecks++;
        if (ov[0] !== 1'b0) $display("[TB] FAIL midreset_no_output: valid=%b want 0", ov[0]);
        else nPass++;
    endtask

    initial begin
        nChecks = 0;
        nPass   = 0;
        mmax[0] = 65535;
        mmax[1] = 15;
        mmax[2] = 65535;
        clearModel();
        idleInputs();
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_saturation();
        test_skid0();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
